// File: rtl/vx_writeback_arb.sv
// Writeback arbiter: picks one register-writing commit source per cycle (round-robin, packet-locked) onto the issue-stage writeback bus.
// Latency: 1 cycle from an accepted writing commit to wb_valid; non-writing commits are acked the same cycle and dropped.
// Backpressure: none downstream; a source sees cmt_ready low while another source holds the grant or a packet lock, and during reset.
module vx_writeback_arb #(
    parameter int CORE_ID     = 0,
    parameter int NUM_REQS    = 4,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int UUID_BITS   = 44,
    parameter int RD_BITS     = 6
) (
    input  logic                              clk,
    input  logic                              reset_n,

    input  logic [NUM_REQS-1:0]               cmt_valid,
    output logic [NUM_REQS-1:0]               cmt_ready,
    input  logic [NUM_REQS*UUID_BITS-1:0]     cmt_uuid,
    input  logic [NUM_REQS*NW_BITS-1:0]       cmt_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0]   cmt_tmask,
    input  logic [NUM_REQS*32-1:0]            cmt_PC,
    input  logic [NUM_REQS*RD_BITS-1:0]       cmt_rd,
    input  logic [NUM_REQS-1:0]               cmt_wb,
    input  logic [NUM_REQS*NUM_THREADS*32-1:0] cmt_data,
    input  logic [NUM_REQS-1:0]               cmt_eop,

    output logic                              wb_valid,
    output logic [UUID_BITS-1:0]              wb_uuid,
    output logic [NW_BITS-1:0]                wb_wid,
    output logic [NUM_THREADS-1:0]            wb_tmask,
    output logic [31:0]                       wb_PC,
    output logic [RD_BITS-1:0]                wb_rd,
    output logic [NUM_THREADS*32-1:0]         wb_data,
    output logic                              wb_eop,

    output logic [31:0]                       perf_wb_count
);

    localparam int IDX_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int DATA_W = NUM_THREADS * 32;

    // CORE_ID only tags trace output elsewhere; reject nonsensical values at elaboration.
    if (CORE_ID < 0) begin : g_bad_core_id
        $error("vx_writeback_arb: CORE_ID must be non-negative");
    end

    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    lock_idx;
    logic                lock_vld;
    logic [NUM_REQS-1:0] eligible;
    logic [NUM_REQS-1:0] grant_oh;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_vld;
    logic                grant_eop;
    logic [IDX_W-1:0]    rr_next;

    // Only writing sources compete; an open packet restricts competition to its owner.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = cmt_valid[i] & cmt_wb[i] & (~lock_vld | (lock_idx == IDX_W'(i)));
        end
    end

    // Round-robin search starting at rr_ptr, wrapping past the last source.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQS;
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign grant_eop = cmt_eop[grant_idx];
    assign rr_next   = (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + IDX_W'(1);

    // Non-writing commits drain immediately; nothing is accepted while reset is held.
    assign cmt_ready = {NUM_REQS{reset_n}} & ((cmt_valid & ~cmt_wb) | grant_oh);

    // Arbitration state: pointer advances only at packet end, lock spans a multi-beat packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else if (grant_vld) begin
            if (grant_eop) begin
                lock_vld <= 1'b0;
                rr_ptr   <= rr_next;
            end else begin
                lock_vld <= 1'b1;
                lock_idx <= grant_idx;
            end
        end
    end

    // Register the granted commit onto the writeback bus; fields hold when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_uuid  <= '0;
            wb_wid   <= '0;
            wb_tmask <= '0;
            wb_PC    <= '0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_eop   <= 1'b0;
        end else begin
            wb_valid <= grant_vld;
            if (grant_vld) begin
                wb_uuid  <= cmt_uuid[int'(grant_idx)*UUID_BITS +: UUID_BITS];
                wb_wid   <= cmt_wid[int'(grant_idx)*NW_BITS +: NW_BITS];
                wb_tmask <= cmt_tmask[int'(grant_idx)*NUM_THREADS +: NUM_THREADS];
                wb_PC    <= cmt_PC[int'(grant_idx)*32 +: 32];
                wb_rd    <= cmt_rd[int'(grant_idx)*RD_BITS +: RD_BITS];
                wb_data  <= cmt_data[int'(grant_idx)*DATA_W +: DATA_W];
                wb_eop   <= grant_eop;
            end
        end
    end

    // Count cycles in which a writeback is presented; wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_wb_count <= '0;
        end else if (wb_valid) begin
            perf_wb_count <= perf_wb_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Directed bench for vx_writeback_arb: round-robin, packet lock, non-writing bypass, data passthrough, reset.
// Inputs change 1 ns after the rising edge; outputs are sampled 1-2 ns after it.
// Each test task does its own inline comparisons and updates the shared counters.
module tb_vx_writeback_arb;

    logic          clk;
    logic          reset_n;
    logic [3:0]    cmt_valid;
    logic [3:0]    cmt_ready;
    logic [175:0]  cmt_uuid;
    logic [7:0]    cmt_wid;
    logic [15:0]   cmt_tmask;
    logic [127:0]  cmt_PC;
    logic [23:0]   cmt_rd;
    logic [3:0]    cmt_wb;
    logic [511:0]  cmt_data;
    logic [3:0]    cmt_eop;
    logic          wb_valid;
    logic [43:0]   wb_uuid;
    logic [1:0]    wb_wid;
    logic [3:0]    wb_tmask;
    logic [31:0]   wb_PC;
    logic [5:0]    wb_rd;
    logic [127:0]  wb_data;
    logic          wb_eop;
    logic [31:0]   perf_wb_count;

    int n_run  = 0;
    int n_fail = 0;

    vx_writeback_arb dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmt_valid     (cmt_valid),
        .cmt_ready     (cmt_ready),
        .cmt_uuid      (cmt_uuid),
        .cmt_wid       (cmt_wid),
        .cmt_tmask     (cmt_tmask),
        .cmt_PC        (cmt_PC),
        .cmt_rd        (cmt_rd),
        .cmt_wb        (cmt_wb),
        .cmt_data      (cmt_data),
        .cmt_eop       (cmt_eop),
        .wb_valid      (wb_valid),
        .wb_uuid       (wb_uuid),
        .wb_wid        (wb_wid),
        .wb_tmask      (wb_tmask),
        .wb_PC         (wb_PC),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_eop        (wb_eop),
        .perf_wb_count (perf_wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source i carries uuid 0x100+tag, wid i, PC 0x8000_0000|tag, rd tag[5:0], lane l = {tag,16'h0,l}.
    task automatic set_src(input int i, input logic v, input logic wb, input logic eop,
                           input logic [7:0] tag, input logic [3:0] tmask);
        cmt_valid[i]            = v;
        cmt_wb[i]               = wb;
        cmt_eop[i]              = eop;
        cmt_uuid[i*44 +: 44]    = 44'h100 + 44'(tag);
        cmt_wid[i*2 +: 2]       = 2'(i);
        cmt_tmask[i*4 +: 4]     = tmask;
        cmt_PC[i*32 +: 32]      = 32'h8000_0000 | 32'(tag);
        cmt_rd[i*6 +: 6]        = tag[5:0];
        for (int l = 0; l < 4; l++) begin
            cmt_data[i*128 + l*32 +: 32] = {tag, 16'h0, 8'(l)};
        end
    endtask

    task automatic clear_all();
        cmt_valid = '0;
        cmt_wb    = '0;
        cmt_eop   = '0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        clear_all();
        cmt_uuid  = '0;
        cmt_wid   = '0;
        cmt_tmask = '0;
        cmt_PC    = '0;
        cmt_rd    = '0;
        cmt_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        n_run++;
        if (perf_wb_count !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d want 0", perf_wb_count); end
        n_run++;
        if (wb_uuid !== 44'd0 || wb_eop !== 1'b0) begin
            n_fail++; $display("FAIL reset_fields: got uuid %h eop %b want 0 0", wb_uuid, wb_eop);
        end
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 1'b1, 1'b1, 8'(i + 1), 4'hF);
        #1;
        n_run++;
        if (cmt_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", cmt_ready); end
        reset_n = 1'b1;
    endtask

    // All four writers valid with single-beat packets: grants rotate 0,1,2,3,0,1,2,3.
    task automatic test_round_robin();
        for (int c = 0; c < 8; c++) begin
            #1;
            n_run++;
            if (cmt_ready !== (4'b0001 << (c % 4))) begin
                n_fail++; $display("FAIL rr_ready c%0d: got %b want %b", c, cmt_ready, 4'b0001 << (c % 4));
            end
            @(posedge clk); #1;
            n_run++;
            if (wb_valid !== 1'b1 || wb_wid !== 2'(c % 4) || wb_uuid !== 44'h101 + 44'(c % 4)) begin
                n_fail++; $display("FAIL rr_wb c%0d: got v%b wid %0d uuid %h want v1 wid %0d uuid %h",
                                   c, wb_valid, wb_wid, wb_uuid, c % 4, 44'h101 + 44'(c % 4));
            end
        end
        clear_all();
        @(posedge clk); #1;
        n_run++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b want 0", wb_valid); end
        n_run++;
        if (perf_wb_count !== 32'd8) begin n_fail++; $display("FAIL rr_perf: got %0d want 8", perf_wb_count); end
    endtask

    // Source 1 sends three beats while source 2 waits; source 2 follows the eop beat.
    task automatic test_packet_lock();
        logic [7:0] tags [3];
        logic       eops [3];
        tags = '{8'h21, 8'h22, 8'h23};
        eops = '{1'b0, 1'b0, 1'b1};
        set_src(2, 1'b1, 1'b1, 1'b1, 8'h30, 4'hF);
        for (int b = 0; b < 3; b++) begin
            set_src(1, 1'b1, 1'b1, eops[b], tags[b], 4'hF);
            #1;
            n_run++;
            if (cmt_ready !== 4'b0010) begin n_fail++; $display("FAIL pkt_ready b%0d: got %b want 0010", b, cmt_ready); end
            @(posedge clk); #1;
            n_run++;
            if (wb_valid !== 1'b1 || wb_uuid !== 44'h100 + 44'(tags[b]) || wb_eop !== eops[b]) begin
                n_fail++; $display("FAIL pkt_wb b%0d: got v%b uuid %h eop %b want v1 uuid %h eop %b",
                                   b, wb_valid, wb_uuid, wb_eop, 44'h100 + 44'(tags[b]), eops[b]);
            end
        end
        cmt_valid[1] = 1'b0;
        #1;
        n_run++;
        if (cmt_ready !== 4'b0100) begin n_fail++; $display("FAIL pkt_next_ready: got %b want 0100", cmt_ready); end
        @(posedge clk); #1;
        n_run++;
        if (wb_valid !== 1'b1 || wb_uuid !== 44'h130 || wb_wid !== 2'd2) begin
            n_fail++; $display("FAIL pkt_next_wb: got v%b uuid %h wid %0d want v1 uuid 130 wid 2", wb_valid, wb_uuid, wb_wid);
        end
        clear_all();
    endtask

    // Lock on source 1 starves source 0 while source 1 idles mid-packet.
    task automatic test_lock_stall();
        set_src(1, 1'b1, 1'b1, 1'b0, 8'h41, 4'hF);
        #1;
        n_run++;
        if (cmt_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_first_ready: got %b want 0010", cmt_ready); end
        @(posedge clk); #1;
        n_run++;
        if (wb_valid !== 1'b1 || wb_uuid !== 44'h141) begin
            n_fail++; $display("FAIL stall_first_wb: got v%b uuid %h want v1 uuid 141", wb_valid, wb_uuid);
        end
        cmt_valid[1] = 1'b0;
        set_src(0, 1'b1, 1'b1, 1'b1, 8'h40, 4'hF);
        for (int j = 0; j < 2; j++) begin
            #1;
            n_run++;
            if (cmt_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready j%0d: got %b want 0000", j, cmt_ready); end
            @(posedge clk); #1;
            n_run++;
            if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL stall_wb_valid j%0d: got %b want 0", j, wb_valid); end
        end
        n_run++;
        if (wb_uuid !== 44'h141) begin n_fail++; $display("FAIL stall_hold: got uuid %h want 141", wb_uuid); end
        set_src(1, 1'b1, 1'b1, 1'b1, 8'h42, 4'hF);
        #1;
        n_run++;
        if (cmt_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_end_ready: got %b want 0010", cmt_ready); end
        @(posedge clk); #1;
        n_run++;
        if (wb_uuid !== 44'h142 || wb_eop !== 1'b1) begin
            n_fail++; $display("FAIL stall_end_wb: got uuid %h eop %b want 142 1", wb_uuid, wb_eop);
        end
        cmt_valid[1] = 1'b0;
        #1;
        n_run++;
        if (cmt_ready !== 4'b0001) begin n_fail++; $display("FAIL stall_src0_ready: got %b want 0001", cmt_ready); end
        @(posedge clk); #1;
        n_run++;
        if (wb_valid !== 1'b1 || wb_uuid !== 44'h140) begin
            n_fail++; $display("FAIL stall_src0_wb: got v%b uuid %h want v1 uuid 140", wb_valid, wb_uuid);
        end
        clear_all();
    endtask

    // Non-writing source 3 is acked alongside the granted writer and never reaches the bus.
    task automatic test_no_wb_bypass();
        set_src(0, 1'b1, 1'b1, 1'b1, 8'h50, 4'hF);
        set_src(3, 1'b1, 1'b0, 1'b1, 8'h53, 4'hF);
        #1;
        n_run++;
        if (cmt_ready !== 4'b1001) begin n_fail++; $display("FAIL bypass_ready: got %b want 1001", cmt_ready); end
        @(posedge clk); #1;
        n_run++;
        if (wb_valid !== 1'b1 || wb_uuid !== 44'h150 || wb_wid !== 2'd0) begin
            n_fail++; $display("FAIL bypass_wb: got v%b uuid %h wid %0d want v1 uuid 150 wid 0", wb_valid, wb_uuid, wb_wid);
        end
        clear_all();
        @(posedge clk); #1;
        n_run++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_pulse: got %b want 0", wb_valid); end
    endtask

    // Lanes with tmask bit clear still pass through untouched.
    task automatic test_data_passthrough();
        set_src(0, 1'b1, 1'b1, 1'b1, 8'h60, 4'b0101);
        cmt_data[127:0] = {32'hD, 32'hC, 32'hB, 32'hA};
        #1;
        n_run++;
        if (cmt_ready !== 4'b0001) begin n_fail++; $display("FAIL data_ready: got %b want 0001", cmt_ready); end
        @(posedge clk); #1;
        n_run++;
        if (wb_data !== 128'h0000000D_0000000C_0000000B_0000000A) begin
            n_fail++; $display("FAIL data_lanes: got %h want 0000000d0000000c0000000b0000000a", wb_data);
        end
        n_run++;
        if (wb_tmask !== 4'b0101 || wb_PC !== 32'h8000_0060 || wb_rd !== 6'h20) begin
            n_fail++; $display("FAIL data_fields: got tmask %b PC %h rd %h want 0101 80000060 20", wb_tmask, wb_PC, wb_rd);
        end
        clear_all();
    endtask

    // Reset during an open packet clears everything; arbitration restarts unlocked at source 0.
    task automatic test_reset_mid_packet();
        set_src(1, 1'b1, 1'b1, 1'b0, 8'h71, 4'hF);
        set_src(2, 1'b1, 1'b1, 1'b1, 8'h72, 4'hF);
        @(posedge clk); #1;
        n_run++;
        if (wb_valid !== 1'b1 || wb_uuid !== 44'h171) begin
            n_fail++; $display("FAIL rst_pkt_start: got v%b uuid %h want v1 uuid 171", wb_valid, wb_uuid);
        end
        set_src(1, 1'b1, 1'b1, 1'b0, 8'h73, 4'hF);
        #2;
        reset_n = 1'b0;
        #1;
        n_run++;
        if (wb_valid !== 1'b0 || cmt_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rst_async: got v%b ready %b want v0 ready 0000", wb_valid, cmt_ready);
        end
        n_run++;
        if (perf_wb_count !== 32'd0) begin n_fail++; $display("FAIL rst_perf: got %0d want 0", perf_wb_count); end
        @(posedge clk); #1;
        n_run++;
        if (cmt_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_held_ready: got %b want 0000", cmt_ready); end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 1'b1, 1'b1, 8'h70 + 8'(i), 4'hF);
        #1;
        n_run++;
        if (cmt_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_restart_ready: got %b want 0001", cmt_ready); end
        cmt_valid = 4'b0100;
        #1;
        n_run++;
        if (cmt_ready !== 4'b0100) begin n_fail++; $display("FAIL rst_src2_ready: got %b want 0100", cmt_ready); end
        @(posedge clk); #1;
        n_run++;
        if (wb_valid !== 1'b1 || wb_uuid !== 44'h172 || wb_wid !== 2'd2) begin
            n_fail++; $display("FAIL rst_src2_wb: got v%b uuid %h wid %0d want v1 uuid 172 wid 2", wb_valid, wb_uuid, wb_wid);
        end
        clear_all();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_lock_stall();
        test_no_wb_bypass();
        test_data_passthrough();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_writeback_arb.md
VX_WRITEBACK_ARB -- requirements
Module: VX_writeback_arb

Interface
REQ-001 SHALL have parameter CORE_ID, default 0, core index used in trace output only.
REQ-002 SHALL have parameter NUM_REQS, default 4, number of commit sources (ALU, LSU, CSR, GPU order).
REQ-003 SHALL have parameter NUM_THREADS, default 4, threads per warp.
REQ-004 SHALL have parameter NW_BITS, default 2, warp-id width.
REQ-005 SHALL have parameter UUID_BITS, default 44, instruction uuid width.
REQ-006 SHALL have parameter RD_BITS, default 6, destination register index width.
REQ-007 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-008 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port cmt_valid  input  NUM_REQS  per-source commit valid.
REQ-010 SHALL have port cmt_ready  output  NUM_REQS  per-source commit accept.
REQ-011 SHALL have port cmt_uuid  input  NUM_REQS*UUID_BITS  per-source uuid.
REQ-012 SHALL have port cmt_wid  input  NUM_REQS*NW_BITS  per-source warp id.
REQ-013 SHALL have port cmt_tmask  input  NUM_REQS*NUM_THREADS  per-source thread mask.
REQ-014 SHALL have port cmt_PC  input  NUM_REQS*32  per-source PC.
REQ-015 SHALL have port cmt_rd  input  NUM_REQS*RD_BITS  per-source destination register.
REQ-016 SHALL have port cmt_wb  input  NUM_REQS  per-source register-write flag.
REQ-017 SHALL have port cmt_data  input  NUM_REQS*NUM_THREADS*32  per-source result data.
REQ-018 SHALL have port cmt_eop  input  NUM_REQS  per-source end-of-packet.
REQ-019 SHALL have ports wb_valid/wb_uuid/wb_wid/wb_tmask/wb_PC/wb_rd/wb_data/wb_eop  output  1/UUID_BITS/NW_BITS/NUM_THREADS/32/RD_BITS/NUM_THREADS*32/1  registered writeback bus to issue stage (scoreboard release and GPR write).
REQ-020 SHALL have port perf_wb_count  output  32  count of writebacks issued.

Function
REQ-021 Transfer on source i SHALL occur when cmt_valid[i] & cmt_ready[i].
REQ-022 Source with cmt_valid=1 and cmt_wb=0 SHALL get cmt_ready=1 same cycle, independent of arbitration, and SHALL not appear on wb bus.
REQ-023 Among sources with cmt_valid=1 and cmt_wb=1, exactly one SHALL be granted per cycle; cmt_ready[i]=1 only for the granted source.
REQ-024 Grant SHALL be round-robin: search starts at pointer rr_ptr (reset 0), wraps from NUM_REQS-1 to 0.
REQ-025 rr_ptr SHALL update to (granted+1) mod NUM_REQS only when the granted transfer has cmt_eop=1.
REQ-026 Lock: transfer with wb=1 and eop=0 from source i SHALL set lock to i; while locked only source i is eligible; lock clears on source i transfer with eop=1.
REQ-027 While locked and source i not valid, no grant SHALL occur and wb_valid SHALL be 0 next cycle.
REQ-028 Latency: granted transfer SHALL appear on wb_* exactly 1 cycle later with wb_valid=1 for one cycle; all fields copied unmodified, including data lanes with tmask bit 0.
REQ-029 No output backpressure; wb_valid SHALL be 0 in cycles following no grant; other wb_* fields hold last value.
REQ-030 perf_wb_count SHALL increment by 1 per wb_valid cycle, wrapping 0xFFFFFFFF to 0.
REQ-031 cmt_ready SHALL be combinational from cmt_valid/cmt_wb/lock/rr_ptr; no combinational path from cmt_data to any output.

Reset
REQ-032 reset_n low SHALL asynchronously clear wb_valid, wb_eop, lock, rr_ptr, perf_wb_count to 0; other wb_* fields to 0.
REQ-033 While reset_n low, cmt_ready SHALL be all 0 (no transfer lost mid-packet); after release arbitration SHALL restart unlocked at source 0.

Verification
REQ-034 Sources 0..3 all valid, wb=1, eop=1, held 8 cycles -> grants 0,1,2,3,0,1,2,3; wb_valid high cycles 2-9; perf_wb_count=8.
REQ-035 Source 1 sends 3 beats eop=0,0,1 while source 2 valid -> wb bus shows source-1 beats contiguously, source 2 granted cycle after eop beat.
REQ-036 Source 3 valid wb=0 alongside source 0 wb=1 -> cmt_ready=4'b1001 same cycle; one wb_valid pulse carrying source 0 fields.
REQ-037 Locked on source 1, source 1 drops valid 2 cycles, source 0 valid -> wb_valid=0 those cycles, cmt_ready[0]=0.
REQ-038 reset_n asserted mid-packet (lock set) -> wb_valid=0 immediately, cmt_ready=0; after release source 2 alone valid -> granted first cycle.
REQ-039 tmask=4'b0101, data lanes 0xA,0xB,0xC,0xD -> wb_data identical, wb_tmask=4'b0101.
